// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator feeder.
// Holds the default operand/address/count widths and the feeder FSM state encoding.
package acc_pkg;

    localparam int unsigned IN_DATA_WIDTH = 8;
    localparam int unsigned AWIDTH        = 10;
    localparam int unsigned CNT_WIDTH     = AWIDTH + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StClear = ST_CLEAR,
        StRun   = ST_RUN,
        StDrain = ST_DRAIN,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/acc_feeder_ctrl.sv
// Upstream control stage for the accumulator.
// On start it clears the accumulator for one cycle, streams N operands out of a
// 1-cycle-latency ROM starting at base_addr (address wraps modulo 2^AWIDTH), and
// pulses done_o in the cycle the accumulator result holds the final sum.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start_i               start command, sampled only in IDLE
//   num_cnt_i             operand count N, latched with start_i
//   base_addr_i           first read address, latched with start_i
//   idle_o / running_o    status (running covers CLEAR, RUN, DRAIN)
//   done_o                one-cycle completion pulse
//   addr_o, ce_o, q_i     ROM read port
//   acc_run_o             accumulator clear
//   acc_valid_o           operand valid (ce_o delayed one cycle)
//   acc_number_o          operand, zero when not valid
module acc_feeder_ctrl #(
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned AWIDTH        = 10,
    parameter int unsigned CNT_WIDTH     = AWIDTH + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [CNT_WIDTH-1:0]     num_cnt_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    output logic                     idle_o,
    output logic                     running_o,
    output logic                     done_o,
    output logic [AWIDTH-1:0]        addr_o,
    output logic                     ce_o,
    input  logic [IN_DATA_WIDTH-1:0] q_i,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o
);

    import acc_pkg::*;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   n_q;
    logic [CNT_WIDTH-1:0]   rd_cnt_q;
    logic [AWIDTH-1:0]      base_q;
    logic [AWIDTH-1:0]      addr_q;
    logic                   valid_q;
    logic                   accept;
    logic                   last_read;

    assign accept    = (state_q == StIdle) && start_i;
    // Only meaningful in RUN, where n_q >= 1.
    assign last_read = (rd_cnt_q == (n_q - 1'b1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StClear;
            StClear: state_d = (n_q == '0) ? StDone : StRun;
            StRun:   if (last_read) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch: later changes on num_cnt_i/base_addr_i are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q    <= '0;
            base_q <= '0;
        end else if (accept) begin
            n_q    <= num_cnt_i;
            base_q <= base_addr_i;
        end
    end

    // Address is loaded at the end of CLEAR so it holds its old value until RUN,
    // and is not advanced past the Nth read so it holds through DRAIN/DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            addr_q   <= '0;
        end else if (state_q == StClear) begin
            rd_cnt_q <= '0;
            addr_q   <= base_q;
        end else if (state_q == StRun) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (!last_read) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    // Aligns valid with the ROM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= ce_o;
        end
    end

    assign idle_o       = (state_q == StIdle);
    assign running_o    = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
    assign done_o       = (state_q == StDone);
    assign ce_o         = (state_q == StRun);
    assign addr_o       = addr_q;
    assign acc_run_o    = (state_q == StClear);
    assign acc_valid_o  = valid_q;
    assign acc_number_o = valid_q ? q_i : '0;

endmodule

// File: tb/tb_acc_feeder_ctrl.sv
module tb_acc_feeder_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int CW  = AW + 1;
    localparam int AW4 = 4;
    localparam int CW4 = AW4 + 1;
    localparam int MEMSZ = 1 << AW;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A (default widths) ----------------
    logic          start = 1'b0;
    logic [CW-1:0] num_cnt = '0;
    logic [AW-1:0] base_addr = '0;
    logic          idle, running, done, ce, acc_run, acc_valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] q = '0;
    logic [DW-1:0] acc_number;

    acc_feeder_ctrl #(
        .IN_DATA_WIDTH (DW),
        .AWIDTH        (AW),
        .CNT_WIDTH     (CW)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start),
        .num_cnt_i    (num_cnt),
        .base_addr_i  (base_addr),
        .idle_o       (idle),
        .running_o    (running),
        .done_o       (done),
        .addr_o       (addr),
        .ce_o         (ce),
        .q_i          (q),
        .acc_run_o    (acc_run),
        .acc_valid_o  (acc_valid),
        .acc_number_o (acc_number)
    );

    // ---------------- DUT B (AWIDTH=4, wrap test) ----------------
    logic           start4 = 1'b0;
    logic [CW4-1:0] num4 = '0;
    logic [AW4-1:0] base4 = '0;
    logic           idle4, running4, done4, ce4, acc_run4, acc_valid4;
    logic [AW4-1:0] addr4;
    logic [DW-1:0]  q4 = '0;
    logic [DW-1:0]  acc_number4;

    acc_feeder_ctrl #(
        .IN_DATA_WIDTH (DW),
        .AWIDTH        (AW4),
        .CNT_WIDTH     (CW4)
    ) u_dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start4),
        .num_cnt_i    (num4),
        .base_addr_i  (base4),
        .idle_o       (idle4),
        .running_o    (running4),
        .done_o       (done4),
        .addr_o       (addr4),
        .ce_o         (ce4),
        .q_i          (q4),
        .acc_run_o    (acc_run4),
        .acc_valid_o  (acc_valid4),
        .acc_number_o (acc_number4)
    );

    // ---------------- environment: ROMs and accumulator stand-ins ----------------
    logic [DW-1:0] mem  [MEMSZ];
    logic [DW-1:0] mem4 [16];

    always @(posedge clk) if (ce)  q  <= mem[addr];
    always @(posedge clk) if (ce4) q4 <= mem4[addr4];

    // Accumulator is not reset by reset_n: it keeps partial state until the next clear.
    int acc_sum = 0, acc_nvalid = 0;
    always @(posedge clk) begin
        if (acc_run) begin
            acc_sum    <= 0;
            acc_nvalid <= 0;
        end else if (acc_valid) begin
            acc_sum    <= acc_sum + int'(acc_number);
            acc_nvalid <= acc_nvalid + 1;
        end
    end

    int acc_sum4 = 0;
    always @(posedge clk) begin
        if (acc_run4)        acc_sum4 <= 0;
        else if (acc_valid4) acc_sum4 <= acc_sum4 + int'(acc_number4);
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    function automatic ev_t mk(input int c, input int a, input int b);
        ev_t e;
        e.cyc = c;
        e.a   = a;
        e.b   = b;
        return e;
    endfunction

    ev_t exp_run_q[$];    // cycle of acc_run pulse
    ev_t exp_ce_q[$];     // cycle, address
    ev_t exp_valid_q[$];  // cycle, operand value
    ev_t exp_done_q[$];   // cycle, sum, operand count

    int cyc = 0;        // index of the current cycle
    int free_cyc = 0;   // first cycle the block is idle again

    // Reference model: a start accepted in cycle s schedules every output event of the run.
    always @(posedge clk) begin
        int n, b, a, s;
        if (reset_n && start && cyc >= free_cyc) begin
            n = int'(num_cnt);
            b = int'(base_addr);
            s = 0;
            exp_run_q.push_back(mk(cyc + 1, 0, 0));
            for (int k = 0; k < n; k++) begin
                a = (b + k) % MEMSZ;
                exp_ce_q.push_back(mk(cyc + 2 + k, a, 0));
                exp_valid_q.push_back(mk(cyc + 3 + k, int'(mem[a]), 0));
                s += int'(mem[a]);
            end
            exp_done_q.push_back(mk(cyc + ((n == 0) ? 2 : n + 3), s, n));
            free_cyc = cyc + ((n == 0) ? 3 : n + 4);
        end
        cyc = cyc + 1;
    end

    // Monitor: compares every output against the scheduled events, mid-cycle.
    always @(negedge clk) begin
        bit e_run, e_ce, e_val, e_done, e_idle;
        e_idle = (cyc >= free_cyc);
        e_run  = (exp_run_q.size()   > 0) && (exp_run_q[0].cyc   == cyc);
        e_ce   = (exp_ce_q.size()    > 0) && (exp_ce_q[0].cyc    == cyc);
        e_val  = (exp_valid_q.size() > 0) && (exp_valid_q[0].cyc == cyc);
        e_done = (exp_done_q.size()  > 0) && (exp_done_q[0].cyc  == cyc);

        chk("idle_o", int'(idle), int'(e_idle));
        chk("running_o", int'(running), int'(!e_idle && !e_done));
        chk("acc_run_o", int'(acc_run), int'(e_run));
        if (e_run) void'(exp_run_q.pop_front());

        chk("ce_o", int'(ce), int'(e_ce));
        if (e_ce) begin
            chk("addr_o", int'(addr), exp_ce_q[0].a);
            void'(exp_ce_q.pop_front());
        end

        chk("acc_valid_o", int'(acc_valid), int'(e_val));
        if (e_val) begin
            chk("acc_number_o", int'(acc_number), exp_valid_q[0].a);
            void'(exp_valid_q.pop_front());
        end else begin
            chk("acc_number_o_idle", int'(acc_number), 0);
        end

        chk("done_o", int'(done), int'(e_done));
        if (e_done) begin
            chk("result_sum", acc_sum, exp_done_q[0].a);
            chk("result_operands", acc_nvalid, exp_done_q[0].b);
            void'(exp_done_q.pop_front());
        end
    end

    // Monitor for the narrow-address instance.
    int exp4_addr_q[$];
    int exp4_sum = 0;
    int exp4_done_cyc = -1;
    int done4_seen = 0;

    always @(negedge clk) begin
        if (ce4) begin
            if (exp4_addr_q.size() == 0) begin
                chk("dut4_unexpected_ce", 1, 0);
            end else begin
                chk("dut4_addr", int'(addr4), exp4_addr_q.pop_front());
            end
        end
        if (done4) begin
            done4_seen++;
            chk("dut4_done_cycle", cyc, exp4_done_cyc);
            chk("dut4_sum", acc_sum4, exp4_sum);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (cyc < free_cyc && guard < 5000) begin
            tick();
            guard++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_idle"}, int'(idle), 1);
        chk({tag, "_running"}, int'(running), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ce"}, int'(ce), 0);
        chk({tag, "_addr"}, int'(addr), 0);
        chk({tag, "_acc_run"}, int'(acc_run), 0);
        chk({tag, "_acc_valid"}, int'(acc_valid), 0);
        chk({tag, "_acc_number"}, int'(acc_number), 0);
    endtask

    task automatic start_run(input int n, input int b);
        num_cnt   = CW'(n);
        base_addr = AW'(b);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        int n, b, guard;

        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = DW'(i + 1);
        for (int i = 0; i < 16; i++) mem4[i] = DW'($urandom);

        #2 reset_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Sum of 1..8 from addresses 0..7.
        start_run(8, 0);
        wait_idle();

        // Empty run.
        start_run(0, 5);
        wait_idle();

        // start held high: back-to-back runs every N+4 cycles.
        num_cnt   = CW'(2);
        base_addr = AW'(3);
        start     = 1'b1;
        repeat (24) tick();
        start = 1'b0;
        wait_idle();

        // Address wrap on the 4-bit instance: 14, 15, 0.
        exp4_addr_q.push_back(14);
        exp4_addr_q.push_back(15);
        exp4_addr_q.push_back(0);
        exp4_sum = int'(mem4[14]) + int'(mem4[15]) + int'(mem4[0]);
        exp4_done_cyc = cyc + 6;
        num4   = CW4'(3);
        base4  = AW4'(14);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        num4   = CW4'(7);
        base4  = AW4'(2);
        guard  = 0;
        while (done4_seen == 0 && guard < 30) begin
            tick();
            guard++;
        end
        chk("dut4_done_seen", done4_seen, 1);
        chk("dut4_addr_left", exp4_addr_q.size(), 0);

        // Randomized runs with mid-run start pulses and command changes.
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            n = $urandom_range(0, 12);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(MEMSZ - 6, MEMSZ - 1)
                                            : $urandom_range(0, MEMSZ - 1);
            start_run(n, b);
            num_cnt   = CW'($urandom_range(0, 15));
            base_addr = AW'($urandom);
            if (n >= 1 && $urandom_range(0, 1) == 1) begin
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();

        // Reset in the third RUN cycle, then a clean N=4 run.
        start_run(6, 100);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        exp_run_q.delete();
        exp_ce_q.delete();
        exp_valid_q.delete();
        exp_done_q.delete();
        free_cyc = cyc;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start_run(4, 20);
        wait_idle();

        guard = 0;
        while ((exp_done_q.size() + exp_ce_q.size() + exp_valid_q.size() +
                exp_run_q.size()) != 0 && guard < 200) begin
            tick();
            guard++;
        end
        chk("pending_events", exp_done_q.size() + exp_ce_q.size() + exp_valid_q.size() +
            exp_run_q.size(), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
